// File: rtl/alu_sequencer.sv
// Command-side controller for the 4-bit combinational ALU: accepts one request per
// three cycles, drives the ALU operands from registers and captures its results.
module alu_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_cmd,
  input  logic [2:0] req_f,
  input  logic [3:0] req_operand,
  output logic [2:0] alu_f,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  input  logic [3:0] alu_y,
  input  logic       alu_carry,
  input  logic       alu_zero,
  output logic [3:0] acc,
  output logic       flag_c,
  output logic       flag_z,
  output logic       done,
  output logic       busy
);

  // One-hot so each handshake output is a single flop bit and cannot glitch.
  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_EXEC = 3'b010,
    S_DONE = 3'b100
  } state_t;

  typedef enum logic [1:0] {
    CMD_EXEC = 2'b00,
    CMD_LOAD = 2'b01,
    CMD_CMP  = 2'b10,
    CMD_CLRF = 2'b11
  } cmd_t;

  state_t     r_state;
  state_t     w_next;
  cmd_t       r_cmd;
  logic [2:0] r_alu_f;
  logic [3:0] r_alu_a;
  logic [3:0] r_alu_b;
  logic [3:0] r_acc;
  logic       r_flag_c;
  logic       r_flag_z;
  logic       w_accept;
  logic       w_write;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (req_valid) w_next = S_EXEC;
      S_EXEC:  w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = r_state[0];
    done      = r_state[2];
    busy      = ~r_state[0];
    w_accept  = r_state[0] & req_valid;
    w_write   = r_state[1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cmd    <= CMD_EXEC;
      r_alu_f  <= 3'b000;
      r_alu_a  <= 4'b0000;
      r_alu_b  <= 4'b0000;
      r_acc    <= 4'b0000;
      r_flag_c <= 1'b0;
      r_flag_z <= 1'b0;
    end else begin
      // NOTE: nonblocking so alu_a captures the accumulator value from before this edge.
      if (w_accept) begin
        r_cmd   <= cmd_t'(req_cmd);
        r_alu_f <= req_f;
        r_alu_a <= r_acc;
        r_alu_b <= req_operand;
      end
      if (w_write) begin
        unique case (r_cmd)
          CMD_EXEC: begin
            r_acc    <= alu_y;
            r_flag_c <= alu_carry;
            r_flag_z <= alu_zero;
          end
          CMD_CMP: begin
            r_flag_c <= alu_carry;
            r_flag_z <= alu_zero;
          end
          CMD_LOAD: begin
            r_acc    <= r_alu_b;
            r_flag_z <= (r_alu_b == 4'b0000);
          end
          CMD_CLRF: begin
            r_flag_c <= 1'b0;
            r_flag_z <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign alu_f  = r_alu_f;
  assign alu_a  = r_alu_a;
  assign alu_b  = r_alu_b;
  assign acc    = r_acc;
  assign flag_c = r_flag_c;
  assign flag_z = r_flag_z;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a combinational ALU on the f/a/b side, a cycle-index
// reference model compared every cycle, directed scenarios and a random phase.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_cmd = 2'b00;
  logic [2:0] req_f = 3'b000;
  logic [3:0] req_operand = 4'h0;
  logic [2:0] alu_f;
  logic [3:0] alu_a, alu_b, alu_y;
  logic       alu_carry, alu_zero;
  logic [3:0] acc;
  logic       flag_c, flag_z, done, busy;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [1:0] EXEC = 2'b00, LOAD = 2'b01, CMP = 2'b10, CLRF = 2'b11;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_f(req_f), .req_operand(req_operand),
    .alu_f(alu_f), .alu_a(alu_a), .alu_b(alu_b),
    .alu_y(alu_y), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .acc(acc), .flag_c(flag_c), .flag_z(flag_z), .done(done), .busy(busy)
  );

  // ALU: returns {carry, y}; subtract reports borrow in the carry bit.
  function automatic logic [4:0] alu_fn(input logic [2:0] f, input logic [3:0] a, input logic [3:0] b);
    case (f)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} - {1'b0, b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {1'b0, a};
      3'd6:    return {1'b0, ~a};
      default: return {1'b0, b};
    endcase
  endfunction

  logic [4:0] w_alu_res;
  assign w_alu_res = alu_fn(alu_f, alu_a, alu_b);
  assign alu_y     = w_alu_res[3:0];
  assign alu_carry = w_alu_res[4];
  assign alu_zero  = (w_alu_res[3:0] == 4'h0);

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the i-th rising edge since time zero is ecount; a command
  // accepted at edge E writes at E+1, pulses done after E+1 and the next
  // acceptance may happen at E+3.
  int         ecount = 0;
  int         acc_edge = -3;
  logic [3:0] m_acc = 4'h0, m_a = 4'h0, m_b = 4'h0;
  logic [2:0] m_f = 3'h0;
  logic [1:0] m_cmd = 2'b00;
  logic       m_c = 1'b0, m_z = 1'b0;
  logic [4:0] m_res;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_acc <= 4'h0; m_a <= 4'h0; m_b <= 4'h0; m_f <= 3'h0; m_cmd <= 2'b00;
      m_c <= 1'b0; m_z <= 1'b0;
      acc_edge <= ecount - 3;
    end else begin
      ecount <= ecount + 1;
      if (ecount == acc_edge) begin
        m_res = alu_fn(m_f, m_a, m_b);
        case (m_cmd)
          EXEC: begin m_acc <= m_res[3:0]; m_c <= m_res[4]; m_z <= (m_res[3:0] == 0); end
          CMP:  begin m_c <= m_res[4]; m_z <= (m_res[3:0] == 0); end
          LOAD: begin m_acc <= m_b; m_z <= (m_b == 0); end
          default: begin m_c <= 1'b0; m_z <= 1'b0; end
        endcase
      end else if (ecount >= acc_edge + 2 && req_valid) begin
        acc_edge <= ecount + 1;
        m_cmd <= req_cmd; m_f <= req_f; m_a <= m_acc; m_b <= req_operand;
      end
    end
  end

  always @(negedge clk) begin
    check("req_ready", int'(req_ready), int'(ecount >= acc_edge + 2));
    check("busy",      int'(busy),      int'(ecount <  acc_edge + 2));
    check("done",      int'(done),      int'(ecount == acc_edge + 1));
    check("acc",       int'(acc),       int'(m_acc));
    check("flag_c",    int'(flag_c),    int'(m_c));
    check("flag_z",    int'(flag_z),    int'(m_z));
    check("alu_f",     int'(alu_f),     int'(m_f));
    check("alu_a",     int'(alu_a),     int'(m_a));
    check("alu_b",     int'(alu_b),     int'(m_b));
  end

  // Called at a negedge; returns at the negedge inside EXEC.
  task automatic issue(input logic [1:0] cmd, input logic [2:0] f, input logic [3:0] op);
    int n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    check("ready_timeout", int'(n < 20), 1);
    req_valid = 1'b1; req_cmd = cmd; req_f = f; req_operand = op;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    int n;
    // Reset held for two cycles.
    repeat (2) @(negedge clk);
    check("rst_acc", int'(acc), 0);
    check("rst_ready", int'(req_ready), 1);
    #1 reset = 1'b1;
    @(negedge clk);
    check("idle_ready", int'(req_ready), 1);
    check("idle_done", int'(done), 0);
    check("idle_alu", int'({alu_f, alu_a, alu_b}), 0);
    check("alu_add_pin", int'(alu_fn(3'd0, 4'hF, 4'h1)), 'h10);
    check("alu_sub_pin", int'(alu_fn(3'd1, 4'h1, 4'h1)), 'h00);

    // LOAD 1111.
    issue(LOAD, 3'd0, 4'hF);
    @(negedge clk);
    check("load_done", int'(done), 1);
    check("load_acc", int'(acc), 'hF);
    check("load_z", int'(flag_z), 0);
    check("model_acc_pin", int'(m_acc), 'hF);
    @(negedge clk);
    check("load_done_once", int'(done), 0);

    // EXEC add 0001 wraps to zero with carry.
    issue(EXEC, 3'd0, 4'h1);
    check("exec_alu_a", int'(alu_a), 'hF);
    check("exec_alu_b", int'(alu_b), 'h1);
    check("exec_busy", int'(busy), 1);
    @(negedge clk);
    check("add_done", int'(done), 1);
    check("add_acc", int'(acc), 0);
    check("add_c", int'(flag_c), 1);
    check("add_z", int'(flag_z), 1);
    @(negedge clk);
    check("add_done_once", int'(done), 0);

    // CLRF with both flags set.
    issue(CLRF, 3'd5, 4'h9);
    @(negedge clk);
    check("clrf_flags", int'({flag_c, flag_z}), 0);
    check("clrf_acc", int'(acc), 0);

    // CMP leaves acc.
    issue(LOAD, 3'd0, 4'h1);
    issue(CMP, 3'd1, 4'h1);
    @(negedge clk);
    check("cmp_acc", int'(acc), 1);
    check("cmp_z", int'(flag_z), 1);

    // Back-to-back with valid held high.
    @(negedge clk);
    req_valid = 1'b1; req_cmd = LOAD; req_f = 3'd0; req_operand = 4'h6;
    @(negedge clk);
    req_cmd = EXEC; req_operand = 4'h3;
    n = 0;
    while (!req_ready && n < 10) begin n++; @(negedge clk); end
    check("b2b_ready_low", n, 2);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_alu_a", int'(alu_a), 6);
    check("b2b_alu_b", int'(alu_b), 3);
    @(negedge clk);
    check("b2b_acc", int'(acc), 9);

    // Reset during EXEC of an EXEC command.
    @(negedge clk);
    issue(EXEC, 3'd0, 4'h5);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_done", int'(done), 0);
    check("abort_acc", int'(acc), 0);
    check("abort_ready", int'(req_ready), 1);
    #1 reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", int'(done), 0);
    end
    issue(LOAD, 3'd0, 4'h7);
    @(negedge clk);
    check("after_abort_done", int'(done), 1);
    check("after_abort_acc", int'(acc), 7);

    // Random phase with occasional asynchronous reset pulses.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      req_valid   = ($urandom_range(0, 9) < 6);
      req_cmd     = 2'($urandom_range(0, 3));
      req_f       = 3'($urandom_range(0, 7));
      req_operand = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 79) == 0) begin
        #2 reset = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
